cu_matrix_c_line_packer: RTL and testbench



---
 rtl/cu_matrix_c_line_packer_pkg.sv | 33 +++
 rtl/cu_matrix_c_line_buffer.sv | 33 +++
 rtl/cu_matrix_c_line_packer.sv | 149 ++++++++++++++
 tb/tb_cu_matrix_c_line_packer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_matrix_c_line_packer_pkg.sv
// Shared constants and types for the matrix-C line packer.
// The line width, the element width, the address alignment and the control ID
// all come from the compute-unit globals.
package cu_matrix_c_line_packer_pkg;

    localparam int DATA_SIZE_WRITE_BITS     = 32;
    localparam int CACHELINE_DATA_WRITE_NUM = 32;
    localparam int CACHELINE_ADDR_BITS      = 64;
    localparam logic [63:0] ADDRESS_DATA_WRITE_ALIGN_MASK = 64'hFFFF_FFFF_FFFF_FF80;
    localparam logic [7:0]  MATRIX_C_CONTROL_ID           = 8'h03;

    // The count must reach CACHELINE_DATA_WRITE_NUM itself, so it needs one extra bit.
    localparam int LINE_COUNT_BITS = $clog2(CACHELINE_DATA_WRITE_NUM) + 1;
    localparam int LINE_DATA_BITS  = CACHELINE_DATA_WRITE_NUM * DATA_SIZE_WRITE_BITS;

    typedef logic [1:0] packer_state_t;
    localparam packer_state_t ST_IDLE  = 2'd0;
    localparam packer_state_t ST_PACK  = 2'd1;
    localparam packer_state_t ST_DRAIN = 2'd2;
    localparam packer_state_t ST_DONE  = 2'd3;

    typedef struct packed {
        logic                           valid;
        logic [CACHELINE_ADDR_BITS-1:0] addr;
        logic [LINE_COUNT_BITS-1:0]     count;
        logic [LINE_DATA_BITS-1:0]      data;
    } line_buf_t;

    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/cu_matrix_c_line_buffer.sv
// One cacheline staging buffer. Words land at the slot given by the current
// count; closing marks the line pending for issue. Releasing it zeroes the data,
// so a short tail line always carries zeros in the slots that were never written.
module cu_matrix_c_line_buffer
    import cu_matrix_c_line_packer_pkg::*;
(
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            wr_en,
    input  logic [DATA_SIZE_WRITE_BITS-1:0] wr_data,
    input  logic                            close_en,
    input  logic [CACHELINE_ADDR_BITS-1:0]  close_addr,
    input  logic                            release_en,
    output line_buf_t                       line
);

    // Append a word, optionally closing the line; a release returns the buffer to empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            line <= '0;
        end else if (release_en) begin
            line <= '0;
        end else if (wr_en) begin
            line.data[line.count[LINE_COUNT_BITS-2:0]*DATA_SIZE_WRITE_BITS +: DATA_SIZE_WRITE_BITS] <= wr_data;
            line.count <= line.count + LINE_COUNT_BITS'(1);
            if (close_en) begin
                line.valid <= 1'b1;
                line.addr  <= close_addr;
            end
        end
    end

endmodule

// File: rtl/cu_matrix_c_line_packer.sv
// Packs the matrix-C result element stream into 128-byte write commands using
// two ping-pong line buffers.
// Optional build macro CU_MATRIX_C_PACKER_BYTE_SWAP_EN: byte-reverse every
// element as it is stored, which gives the host little-endian layout.
//
// state | meaning
// IDLE  | no job yet; descriptors accepted when enabled
// PACK  | accepting elements into the fill buffer
// DRAIN | all elements taken; waiting for pending lines to issue
// DONE  | job complete (done_out high); descriptors accepted when enabled
module cu_matrix_c_line_packer
    import cu_matrix_c_line_packer_pkg::*;
#(
    parameter int         DATA_W     = DATA_SIZE_WRITE_BITS,
    parameter int         LINE_WORDS = CACHELINE_DATA_WRITE_NUM,
    parameter int         ADDR_W     = CACHELINE_ADDR_BITS,
    parameter logic [7:0] CU_ID      = MATRIX_C_CONTROL_ID
)(
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enabled_in,
    input  logic                         job_valid_in,
    input  logic [ADDR_W-1:0]            job_base_addr_in,
    input  logic [31:0]                  job_num_elems_in,
    output logic                         job_ready_out,
    input  logic                         elem_valid_in,
    input  logic [DATA_W-1:0]            elem_data_in,
    output logic                         elem_ready_out,
    output logic                         cmd_valid_out,
    output logic [ADDR_W-1:0]            cmd_address_out,
    output logic [7:0]                   cmd_size_out,
    output logic [7:0]                   cmd_cu_id_out,
    output logic [LINE_WORDS*DATA_W-1:0] cmd_data_out,
    input  logic                         cmd_ready_in,
    output logic                         done_out,
    output logic [31:0]                  lines_issued_out
);

    localparam logic [ADDR_W-1:0] LINE_BYTES = ADDR_W'(LINE_WORDS * DATA_W / 8);

    packer_state_t     state;
    logic              fill_sel;
    logic              issue_sel;
    logic [31:0]       remaining;
    logic [ADDR_W-1:0] line_addr;
    line_buf_t         buf0, buf1, fill_line, cur_line;
    logic [DATA_W-1:0] elem_word;
    logic              job_fire, elem_fire, cmd_fire, line_close, drain_done;

`ifdef CU_MATRIX_C_PACKER_BYTE_SWAP_EN
    assign elem_word = byte_swap32(elem_data_in);
`else
    assign elem_word = elem_data_in;
`endif

    assign fill_line = fill_sel  ? buf1 : buf0;
    assign cur_line  = issue_sel ? buf1 : buf0;

    // Reset is asynchronous, so ready is masked by it too to keep every output low during reset.
    assign job_ready_out  = !reset && enabled_in && (state == ST_IDLE || state == ST_DONE);
    assign elem_ready_out = (state == ST_PACK) && !fill_line.valid;
    assign job_fire       = job_valid_in && job_ready_out;
    assign elem_fire      = elem_valid_in && elem_ready_out;
    assign cmd_fire       = cmd_valid_out && cmd_ready_in;
    assign line_close     = elem_fire && (remaining == 32'd1 ||
                            fill_line.count == LINE_COUNT_BITS'(LINE_WORDS - 1));

    // The buffer being handshaken this cycle counts as already free, so done follows the last issue directly.
    assign drain_done = (!buf0.valid || (cmd_fire && !issue_sel)) &&
                        (!buf1.valid || (cmd_fire &&  issue_sel));

    assign cmd_valid_out   = cur_line.valid;
    assign cmd_address_out = cur_line.addr;
    assign cmd_size_out    = {cur_line.count, 2'b00};
    assign cmd_cu_id_out   = cur_line.valid ? CU_ID : 8'd0;
    assign cmd_data_out    = cur_line.data;

    cu_matrix_c_line_buffer u_buf0 (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (elem_fire && !fill_sel),
        .wr_data    (elem_word),
        .close_en   (line_close && !fill_sel),
        .close_addr (line_addr),
        .release_en (cmd_fire && !issue_sel),
        .line       (buf0)
    );

    cu_matrix_c_line_buffer u_buf1 (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (elem_fire && fill_sel),
        .wr_data    (elem_word),
        .close_en   (line_close && fill_sel),
        .close_addr (line_addr),
        .release_en (cmd_fire && issue_sel),
        .line       (buf1)
    );

    // Job sequencing, element accounting, and ping-pong fill/issue pointers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= ST_IDLE;
            fill_sel         <= 1'b0;
            issue_sel        <= 1'b0;
            remaining        <= '0;
            line_addr        <= '0;
            done_out         <= 1'b0;
            lines_issued_out <= '0;
        end else begin
            if (cmd_fire) begin
                issue_sel <= !issue_sel;
                if (lines_issued_out != 32'hFFFF_FFFF)
                    lines_issued_out <= lines_issued_out + 32'd1;
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (job_fire) begin
                        remaining        <= job_num_elems_in;
                        line_addr        <= job_base_addr_in & ADDRESS_DATA_WRITE_ALIGN_MASK;
                        lines_issued_out <= '0;
                        fill_sel         <= 1'b0;
                        issue_sel        <= 1'b0;
                        done_out         <= (job_num_elems_in == 32'd0);
                        state            <= (job_num_elems_in == 32'd0) ? ST_DONE : ST_PACK;
                    end
                end
                ST_PACK: begin
                    if (elem_fire) begin
                        remaining <= remaining - 32'd1;
                        if (line_close) begin
                            fill_sel  <= !fill_sel;
                            line_addr <= line_addr + LINE_BYTES;
                        end
                        if (remaining == 32'd1)
                            state <= ST_DRAIN;
                    end
                end
                default: begin
                    if (drain_done) begin
                        state    <= ST_DONE;
                        done_out <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cu_matrix_c_line_packer.sv
// Self-checking bench for the matrix-C line packer: directed jobs, a queue of
// expected commands computed from the line-packing rules, and one negedge
// monitor that checks every command handshake and hold cycle.
module tb_cu_matrix_c_line_packer;

    logic          clock = 1'b0;
    logic          reset;
    logic          enabled_in;
    logic          job_valid_in;
    logic [63:0]   job_base_addr_in;
    logic [31:0]   job_num_elems_in;
    logic          job_ready_out;
    logic          elem_valid_in;
    logic [31:0]   elem_data_in;
    logic          elem_ready_out;
    logic          cmd_valid_out;
    logic [63:0]   cmd_address_out;
    logic [7:0]    cmd_size_out;
    logic [7:0]    cmd_cu_id_out;
    logic [1023:0] cmd_data_out;
    logic          cmd_ready_in;
    logic          done_out;
    logic [31:0]   lines_issued_out;

    localparam logic [7:0] EXP_CU_ID = 8'h03;

    cu_matrix_c_line_packer dut (
        .clock            (clock),
        .reset            (reset),
        .enabled_in       (enabled_in),
        .job_valid_in     (job_valid_in),
        .job_base_addr_in (job_base_addr_in),
        .job_num_elems_in (job_num_elems_in),
        .job_ready_out    (job_ready_out),
        .elem_valid_in    (elem_valid_in),
        .elem_data_in     (elem_data_in),
        .elem_ready_out   (elem_ready_out),
        .cmd_valid_out    (cmd_valid_out),
        .cmd_address_out  (cmd_address_out),
        .cmd_size_out     (cmd_size_out),
        .cmd_cu_id_out    (cmd_cu_id_out),
        .cmd_data_out     (cmd_data_out),
        .cmd_ready_in     (cmd_ready_in),
        .done_out         (done_out),
        .lines_issued_out (lines_issued_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0]   addr;
        logic [7:0]    size;
        logic [1023:0] data;
    } exp_cmd_t;

    exp_cmd_t      exp_q[$];
    logic [63:0]   got_addr[$];
    logic [7:0]    got_size[$];
    logic [1023:0] got_data[$];

    int n_checks = 0;
    int n_fail   = 0;

    int job_count = 0;
    int job_hold  = 0;
    int elem_cnt  = 0;
    int stall_cnt = 0;
    bit stalled   = 0;

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timeout, expected event did not occur", name);
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] w);
`ifdef CU_MATRIX_C_PACKER_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Monitor: command order/content, hold stability, latency and done timing.
    bit            hold_pending = 0;
    bit            done_chk = 0;
    bit            lat_chk  = 0;
    logic [63:0]   prev_addr;
    logic [7:0]    prev_size;
    logic [1023:0] prev_data;
    exp_cmd_t      e;

    always @(negedge clock) begin
        if (reset) begin
            hold_pending = 0;
            done_chk     = 0;
            lat_chk      = 0;
        end else begin
            if (done_chk) begin
                check("done_after_last_cmd", done_out, 1'b1);
                done_chk = 0;
            end
            if (lat_chk) begin
                check("cmd_valid_after_close", cmd_valid_out, 1'b1);
                lat_chk = 0;
            end
            if (hold_pending) begin
                check("hold_valid", cmd_valid_out, 1'b1);
                check("hold_addr", cmd_address_out, prev_addr);
                check("hold_size", cmd_size_out, prev_size);
                check("hold_data", cmd_data_out, prev_data);
            end
            hold_pending = cmd_valid_out && !cmd_ready_in;
            prev_addr = cmd_address_out;
            prev_size = cmd_size_out;
            prev_data = cmd_data_out;

            if (job_valid_in && job_ready_out) begin
                elem_cnt = 0;
                stalled  = 0;
                stall_cnt = 0;
            end
            if (elem_valid_in && !elem_ready_out && !stalled) begin
                stalled   = 1;
                stall_cnt = elem_cnt;
            end
            if (elem_valid_in && elem_ready_out) begin
                elem_cnt++;
                if (job_hold == 0 && (elem_cnt % 32 == 0 || elem_cnt == job_count))
                    lat_chk = 1;
            end
            if (cmd_valid_out && cmd_ready_in) begin
                got_addr.push_back(cmd_address_out);
                got_size.push_back(cmd_size_out);
                got_data.push_back(cmd_data_out);
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_cmd");
                end else begin
                    e = exp_q.pop_front();
                    check("cmd_addr", cmd_address_out, e.addr);
                    check("cmd_size", cmd_size_out, e.size);
                    check("cmd_cu_id", cmd_cu_id_out, EXP_CU_ID);
                    check("cmd_data", cmd_data_out, e.data);
                    if (exp_q.size() == 0) begin
                        check("done_low_at_last_cmd", done_out, 1'b0);
                        done_chk = 1;
                    end
                end
            end
        end
    end

    task automatic start_job(input logic [63:0] base, input int count);
        bit acc;
        int t = 0;
        job_count        = count;
        job_valid_in     = 1'b1;
        job_base_addr_in = base;
        job_num_elems_in = 32'(count);
        do begin
            @(negedge clock);
            acc = job_ready_out;
            @(posedge clock);
            #1;
            t++;
        end while (!acc && t < 20);
        job_valid_in = 1'b0;
        if (!acc) fail_now("job_handshake");
    endtask

    task automatic send_elem(input logic [31:0] v);
        bit acc;
        int t = 0;
        elem_valid_in = 1'b1;
        elem_data_in  = v;
        do begin
            @(negedge clock);
            acc = elem_ready_out;
            @(posedge clock);
            #1;
            t++;
        end while (!acc && t < 200);
        if (!acc) fail_now("elem_handshake");
    endtask

    // Build expected commands from the packing rules, run the job, and check its end state.
    task automatic run_job(input logic [63:0] base, input int count,
                           input logic [31:0] first_val, input int hold);
        exp_cmd_t x;
        int words;
        int lines = 0;
        int t = 0;
        for (int n = 0; n * 32 < count; n++) begin
            words  = (count - n * 32 > 32) ? 32 : count - n * 32;
            x.addr = (base & ~64'h7F) + 64'(n) * 64'd128;
            x.size = 8'(words * 4);
            x.data = '0;
            for (int k = 0; k < words; k++)
                x.data[k*32 +: 32] = model_word(first_val + 32'(n * 32 + k));
            exp_q.push_back(x);
            lines++;
        end
        got_addr.delete();
        got_size.delete();
        got_data.delete();
        job_hold     = hold;
        cmd_ready_in = (hold == 0);
        start_job(base, count);
        fork
            begin
                for (int i = 0; i < count; i++)
                    send_elem(first_val + 32'(i));
                elem_valid_in = 1'b0;
            end
            begin
                if (hold > 0) begin
                    int w = 0;
                    while (!stalled && w < 300) begin
                        @(posedge clock);
                        w++;
                    end
                    if (!stalled) fail_now("backpressure_stall");
                    repeat (hold) @(posedge clock);
                    #1;
                    cmd_ready_in = 1'b1;
                end
            end
        join
        while (!done_out && t < 300) begin
            @(negedge clock);
            t++;
        end
        if (!done_out) fail_now("job_done");
        @(posedge clock);
        #1;
        check("all_cmds_seen", 32'(exp_q.size()), 32'd0);
        check("lines_issued", lines_issued_out, 32'(lines));
        if (hold == 0) check("no_stall_ready_high", stalled, 1'b0);
        exp_q.delete();
    endtask

    logic [1023:0] tmp_data;

    initial begin
        reset            = 1'b1;
        enabled_in       = 1'b1;
        job_valid_in     = 1'b0;
        job_base_addr_in = '0;
        job_num_elems_in = '0;
        elem_valid_in    = 1'b0;
        elem_data_in     = '0;
        cmd_ready_in     = 1'b0;
        #1;
        check("rst_job_ready", job_ready_out, 1'b0);
        check("rst_elem_ready", elem_ready_out, 1'b0);
        check("rst_cmd_valid", cmd_valid_out, 1'b0);
        check("rst_done", done_out, 1'b0);
        check("rst_lines", lines_issued_out, 32'd0);
        check("rst_cmd_size", cmd_size_out, 8'd0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        enabled_in = 1'b0;
        @(negedge clock);
        check("job_ready_disabled", job_ready_out, 1'b0);
        enabled_in = 1'b1;
        @(negedge clock);
        check("job_ready_idle", job_ready_out, 1'b1);
        @(posedge clock);
        #1;

        // Full line
        run_job(64'h1000, 32, 32'h0, 0);
        check("full_n_cmds", 32'(got_addr.size()), 32'd1);
        check("full_addr", got_addr[0], 64'h1000);
        check("full_size", got_size[0], 8'd128);
        tmp_data = got_data[0];
        check("full_word5", tmp_data[5*32 +: 32], model_word(32'd5));

        // Partial tail with unaligned base
        run_job(64'h2040, 40, 32'h100, 0);
        check("tail_n_cmds", 32'(got_addr.size()), 32'd2);
        check("tail_addr0", got_addr[0], 64'h2000);
        check("tail_size0", got_size[0], 8'd128);
        check("tail_addr1", got_addr[1], 64'h2080);
        check("tail_size1", got_size[1], 8'd32);
        tmp_data = got_data[1];
        check("tail_word8_zero", tmp_data[8*32 +: 32], 32'd0);
        check("tail_word31_zero", tmp_data[31*32 +: 32], 32'd0);

        // Back-pressure
        run_job(64'h3000, 96, 32'h5000, 50);
        check("bp_stall_at", 32'(stall_cnt), 32'd64);
        check("bp_n_cmds", 32'(got_addr.size()), 32'd3);
        check("bp_addr2", got_addr[2], 64'h3100);

        // Zero count
        job_hold     = 0;
        cmd_ready_in = 1'b1;
        start_job(64'h4000, 0);
        @(negedge clock);
        check("zero_done", done_out, 1'b1);
        check("zero_cmd_valid", cmd_valid_out, 1'b0);
        check("zero_lines", lines_issued_out, 32'd0);
        repeat (3) @(negedge clock);
        check("zero_cmd_valid_later", cmd_valid_out, 1'b0);
        @(posedge clock);
        #1;

        // Byte order of a single-element line
        run_job(64'h5000, 1, 32'h11223344, 0);
        check("swap_size", got_size[0], 8'd4);
        tmp_data = got_data[0];
`ifdef CU_MATRIX_C_PACKER_BYTE_SWAP_EN
        check("swap_word0", tmp_data[31:0], 32'h44332211);
`else
        check("swap_word0", tmp_data[31:0], 32'h11223344);
`endif

        // Reset with a command pending
        job_hold     = 1;
        cmd_ready_in = 1'b0;
        start_job(64'h6000, 64);
        for (int i = 0; i < 32; i++)
            send_elem(32'hA000 + 32'(i));
        elem_valid_in = 1'b0;
        @(negedge clock);
        check("pre_reset_cmd_valid", cmd_valid_out, 1'b1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_cmd_valid", cmd_valid_out, 1'b0);
        check("mid_rst_elem_ready", elem_ready_out, 1'b0);
        check("mid_rst_job_ready", job_ready_out, 1'b0);
        check("mid_rst_done", done_out, 1'b0);
        check("mid_rst_lines", lines_issued_out, 32'd0);
        check("mid_rst_addr", cmd_address_out, 64'd0);
        check("mid_rst_size", cmd_size_out, 8'd0);
        check("mid_rst_cu_id", cmd_cu_id_out, 8'd0);
        check("mid_rst_data", cmd_data_out, 1024'd0);
        exp_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        run_job(64'h1000, 32, 32'h0, 0);
        check("post_rst_n_cmds", 32'(got_addr.size()), 32'd1);
        check("post_rst_addr", got_addr[0], 64'h1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
